// File: rtl/nibble_serial_adder_pkg.sv
// Shared widths and FSM encodings for the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;

  localparam int WIDTH    = 16;
  localparam int NIBBLE_W = 4;
  localparam int NIBBLES  = WIDTH / NIBBLE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_fulladder4.sv
// 4-bit ripple adder slice used once per clock by the serial sequencer.
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  // Explicit ripple chain through four single-bit full adders.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract: one nibble per clock through a single fulladder4,
// LSB nibble first, carry registered between nibbles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; result and flags held
// ST_RUN  | one nibble computed per cycle, idx_q selects the slice
// ST_DONE | one-cycle done pulse; a start here begins the next op at once
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  A,
  input  logic [NIBBLE_W*NIBBLES-1:0]  B,
  input  logic                         Cin,
  input  logic                         sub,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  SUM,
  output logic                         CO,
  output logic                         Ofl,
  output logic                         Zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [W-1:0]         a_q, beff_q;
  logic                 carry_q;
  logic                 accept, finish;
  logic [NIBBLE_W-1:0]  fa_a, fa_b, fa_s;
  logic                 fa_co;
  logic [W-1:0]         sum_d;
  logic                 ofl_d;

  fulladder4 u_fa (
    .a  (fa_a),
    .b  (fa_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode, status outputs and start acceptance.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    finish = busy && (idx_q == LAST_IDX);
  end

  // Nibble mux into the adder and merge of its sum into the full result;
  // overflow looks at the merged result so it is correct on the last nibble.
  always_comb begin
    fa_a  = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    fa_b  = beff_q[NIBBLE_W*idx_q +: NIBBLE_W];
    sum_d = SUM;
    sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = fa_s;
    ofl_d = (a_q[W-1] == beff_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
  end

  // Operand capture, nibble stepping and flag update on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      beff_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      SUM     <= '0;
      CO      <= 1'b0;
      Ofl     <= 1'b0;
      Zero    <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      beff_q  <= sub ? ~B : B;
      carry_q <= sub | Cin;
      idx_q   <= '0;
    end else if (busy) begin
      SUM     <= sum_d;
      carry_q <= fa_co;
      idx_q   <= idx_q + 1'b1;
      if (finish) begin
        CO   <= fa_co;
        Ofl  <= ofl_d;
        Zero <= (sum_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops on done.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, CO, Ofl, Zero;
  logic [15:0] SUM;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ofl;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .SUM   (SUM),
    .CO    (CO),
    .Ofl   (Ofl),
    .Zero  (Zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives a start at the current negedge; done is due 5 cycles later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic s, input logic [15:0] esum, input logic eco,
                       input logic eofl, input logic ezero);
    exp_t e;
    A = a; B = b; Cin = ci; sub = s; start = 1'b1;
    e.sum = esum; e.co = eco; e.ofl = eofl; e.zero = ezero; e.cyc = cyc + 5;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("SUM", SUM, e.sum);
        check("CO", CO, e.co);
        check("Ofl", Ofl, e.ofl);
        check("Zero", Zero, e.zero);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_SUM", SUM, 0);
    check("rst_flags", {CO, Ofl, Zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Plain add with latency probes.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    check("busy_c1", busy, 1);
    check("done_c1", done, 0);
    drain();

    // Full carry ripple to zero.
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Subtractions; Cin must be ignored when sub=1.
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drain();
    issue(16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();
    issue(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    drain();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-to-back: second start during the DONE cycle of the first.
    k = cyc;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    wait_cyc(k + 5);
    check("b2b_done", done, 1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    check("b2b_no_gap", busy, 1);
    drain();

    // Start and operand changes while busy must not disturb the result.
    issue(16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Leave nonzero SUM/CO/Ofl, then abort an op with reset in cycle 3.
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drain();
    k = cyc;
    A = 16'h4444; B = 16'h1111; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(k + 3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_SUM", SUM, 0);
    check("abort_flags", {CO, Ofl, Zero}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_idle_SUM", SUM, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
